// File: rtl/regfile_pkg.sv
// Shared types and helpers for the pipelined-core register file with scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  // Widest register address the helpers accept (NREGS up to 256).
  localparam int ADDR_MAX_W = 8;
  typedef logic [ADDR_MAX_W-1:0] addr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic addr_hit(input addr_t a, input addr_t b, input logic en);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between the issue/write-back stages and the register file.
interface regfile_if #(
  parameter int XLEN  = regfile_pkg::XLEN_DEF,
  parameter int NREGS = regfile_pkg::NREGS_DEF,
  parameter int NRD   = regfile_pkg::NRD_DEF
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  // wr_en and alloc_en are single-cycle strobes with no backpressure; a write is
  // always taken in RUN, an allocation only when alloc_ok is high in that same cycle.
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                alloc_ok;
  logic                init_busy;
  logic [CW-1:0]       busy_cnt;
  regfile_pkg::state_t dbg_state;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rs_data, rs_busy, alloc_ok, init_busy, busy_cnt, dbg_state
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rs_data, rs_busy, alloc_ok, init_busy, busy_cnt, dbg_state
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: reserves destinations, releases them on write-back,
// and keeps a running count of reserved registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic              i_alloc_en,
  input  logic [AW-1:0]     i_alloc_addr,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD-1:0]    o_rd_busy,
  output logic              o_alloc_ok,
  output logic [CW-1:0]     o_busy_cnt
);

  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_sb_n;
  logic [CW-1:0]    r_cnt;
  logic w_wr_eff, w_wr_clr, w_alloc_hit_wr, w_alloc_set, w_inc, w_dec;

  assign w_wr_eff       = i_run & i_wr_en & !(ZERO_REG && (i_wr_addr == '0));
  assign w_wr_clr       = w_wr_eff & r_sb[i_wr_addr];
  assign w_alloc_hit_wr = addr_hit(addr_t'(i_wr_addr), addr_t'(i_alloc_addr), i_wr_en);
  assign o_alloc_ok     = i_run & i_alloc_en & ~(r_sb[i_alloc_addr] & ~w_alloc_hit_wr);
  assign w_alloc_set    = o_alloc_ok & !(ZERO_REG && (i_alloc_addr == '0));

  // A release and a re-reservation of the same register cancel in the count.
  assign w_inc = w_alloc_set & ~r_sb[i_alloc_addr];
  assign w_dec = w_wr_clr & ~(w_alloc_set & w_alloc_hit_wr);

  always_comb begin
    w_sb_n = r_sb;
    if (w_wr_eff)    w_sb_n[i_wr_addr]    = 1'b0;
    if (w_alloc_set) w_sb_n[i_alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sb  <= '0;
      r_cnt <= '0;
    end else begin
      r_sb  <= w_sb_n;
      r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  assign o_busy_cnt = r_cnt;

  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [AW-1:0] w_ra;
    assign w_ra = i_rd_addr[k*AW +: AW];
    assign o_rd_busy[k] = r_sb[w_ra]
                        & ~addr_hit(addr_t'(i_wr_addr), addr_t'(w_ra), i_wr_en)
                        & !(ZERO_REG && (w_ra == '0));
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass, hardwired zero register,
// a sequential post-reset clear engine and an integrated scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_t                     r_state, w_state_n;
  logic [AW-1:0]              r_clr_ptr;
  logic [XLEN-1:0]            r_mem [NREGS];
  logic [NRD-1:0][XLEN-1:0]   w_rs_data;
  logic                       w_run, w_wr_eff;

  assign w_run    = (r_state == RUN);
  assign w_wr_eff = w_run & bus.wr_en & !(ZERO_REG && (bus.wr_addr == '0));

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      CLEAR:   if (r_clr_ptr == AW'(NREGS - 1)) w_state_n = RUN;
      RUN:     w_state_n = RUN;
      default: w_state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == CLEAR) r_clr_ptr <= r_clr_ptr + AW'(1);
    end
  end

  // The array has no reset fan-out; the clear engine zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == CLEAR)  r_mem[r_clr_ptr] <= '0;
      else if (w_wr_eff)     r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = bus.rs_addr[k*AW +: AW];
    assign w_rs_data[k] =
        (!w_run || (ZERO_REG && (w_ra == '0)))                      ? '0 :
        addr_hit(addr_t'(bus.wr_addr), addr_t'(w_ra), bus.wr_en)    ? bus.wr_data :
                                                                       r_mem[w_ra];
  end

  assign bus.rs_data   = w_rs_data;
  assign bus.init_busy = (r_state == CLEAR);
  assign bus.dbg_state = r_state;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run        (w_run),
    .i_wr_en      (bus.wr_en),
    .i_wr_addr    (bus.wr_addr),
    .i_alloc_en   (bus.alloc_en),
    .i_alloc_addr (bus.alloc_addr),
    .i_rd_addr    (bus.rs_addr),
    .o_rd_busy    (bus.rs_busy),
    .o_alloc_ok   (bus.alloc_ok),
    .o_busy_cnt   (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against an
// array-based reference model, compared through an expected-response queue.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);
  localparam int EW    = 2*XLEN + 4 + 6;

  logic clk;
  logic rst_n;

  regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_sb  [NREGS];
  int              m_left;
  bit              m_known;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_bad;
  int ib_cycles;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bus.init_busy === 1'b1) ib_cycles++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rs_data1",  bus.rs_data[2*XLEN-1:XLEN], e[73:42]);
      check("rs_data0",  bus.rs_data[XLEN-1:0],      e[41:10]);
      check("rs_busy",   32'(bus.rs_busy),           32'(e[9:8]));
      check("alloc_ok",  32'(bus.alloc_ok),          32'(e[7]));
      check("init_busy", 32'(bus.init_busy),         32'(e[6]));
      check("busy_cnt",  32'(bus.busy_cnt),          32'(e[5:0]));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input int a0, input int a1,
                       input bit we, input int wa, input logic [XLEN-1:0] wd,
                       input bit ae, input int aa);
    logic [XLEN-1:0] d [2];
    bit b [2];
    int a [2];
    bit ok, run;
    int cnt;
    rst_n          = rst;
    bus.rs_addr    = {AW'(a1), AW'(a0)};
    bus.wr_en      = we;
    bus.wr_addr    = AW'(wa);
    bus.wr_data    = wd;
    bus.alloc_en   = ae;
    bus.alloc_addr = AW'(aa);
    a[0] = a0;
    a[1] = a1;
    run  = (m_left == 0);
    for (int k = 0; k < 2; k++) begin
      if (!run || a[k] == 0)          d[k] = '0;
      else if (we && wa == a[k])      d[k] = wd;
      else                            d[k] = m_mem[a[k]];
      b[k] = run && a[k] != 0 && m_sb[a[k]] && !(we && wa == a[k]);
    end
    ok  = run && ae && (aa == 0 || !m_sb[aa] || (we && wa == aa));
    cnt = 0;
    for (int i = 0; i < NREGS; i++) cnt += int'(m_sb[i]);
    if (m_known) exp_q.push_back({d[1], d[0], b[1], b[0], ok, !run, 6'(cnt)});
    @(posedge clk);
    if (!rst) begin
      m_known = 1'b1;
      m_left  = NREGS;
      for (int i = 0; i < NREGS; i++) begin
        m_mem[i] = '0;
        m_sb[i]  = 1'b0;
      end
    end else if (m_known) begin
      if (run) begin
        if (we && wa != 0) begin
          m_mem[wa] = wd;
          m_sb[wa]  = 1'b0;
        end
        if (ok && aa != 0) m_sb[aa] = 1'b1;
      end else begin
        m_left--;
      end
    end
    #1;
  endtask

  task automatic idle(input int a0, input int a1);
    drive(1'b1, a0, a1, 1'b0, 0, '0, 1'b0, 0);
  endtask

  // Runs out the clear sequence and checks that init_busy lasted exactly NREGS cycles.
  task automatic finish_clear(input int start);
    int guard = 0;
    while (m_left > 0 && guard < 100) begin
      idle(guard % NREGS, 5);
      guard++;
    end
    idle(5, 0);
    check("init_len", 32'(ib_cycles - start), 32'(NREGS));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    n_vec = 0; n_bad = 0; ib_cycles = 0; m_known = 1'b0; m_left = NREGS;
    rst_n = 1'b0;
    bus.rs_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0;
    @(posedge clk); #1;

    drive(1'b0, 0, 1, 1'b0, 0, '0, 1'b0, 0);
    drive(1'b0, 0, 1, 1'b0, 0, '0, 1'b1, 3);
    start = ib_cycles;
    drive(1'b1, 5, 7, 1'b1, 5, 32'hDEAD, 1'b1, 4);
    finish_clear(start);

    drive(1'b1, 7, 5, 1'b1, 7, 32'h1234_5678, 1'b0, 0);
    idle(7, 5);
    drive(1'b1, 0, 7, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0);
    idle(0, 0);
    drive(1'b1, 0, 3, 1'b0, 0, '0, 1'b1, 0);

    drive(1'b1, 3, 0, 1'b0, 0, '0, 1'b1, 3);
    drive(1'b1, 3, 0, 1'b0, 0, '0, 1'b1, 3);
    drive(1'b1, 3, 3, 1'b1, 3, 32'hCAFE_0003, 1'b0, 0);
    idle(3, 0);

    drive(1'b1, 9, 0, 1'b0, 0, '0, 1'b1, 9);
    drive(1'b1, 9, 9, 1'b1, 9, 32'h0000_0909, 1'b1, 9);
    idle(9, 0);

    drive(1'b1, 1, 2, 1'b0, 0, '0, 1'b1, 1);
    drive(1'b1, 1, 2, 1'b0, 0, '0, 1'b1, 2);
    drive(1'b1, 4, 6, 1'b0, 0, '0, 1'b1, 4);
    drive(1'b1, 4, 6, 1'b0, 0, '0, 1'b1, 6);
    for (int i = 0; i < 5; i++) idle(i + 1, 9);
    drive(1'b0, 1, 9, 1'b1, 2, 32'h5555, 1'b1, 11);
    start = ib_cycles;
    idle(1, 9);
    finish_clear(start);

    for (int i = 0; i < 400; i++) begin
      int lim;
      lim = ($urandom_range(0, 1) == 1) ? 7 : NREGS - 1;
      drive(($urandom_range(0, 299) != 0),
            $urandom_range(0, lim), $urandom_range(0, lim),
            1'($urandom_range(0, 1)), $urandom_range(0, lim), $urandom(),
            1'($urandom_range(0, 1)), $urandom_range(0, lim));
    end
    idle(0, 0);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
